// File: rtl/veritune_peak_bin_finder.sv
// Scans a bin range of the FFT result buffer and reports the bin with the
// largest Re^2+Im^2, using a three-stage read / square / compare pipeline.
module veritune_peak_bin_finder #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int FIRST_BIN = 1,
    parameter int LAST_BIN  = 511,
    parameter int MIN_MAG   = 0
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     Start,
    input  logic                     Ack,
    output logic [ADDR_W-1:0]        Rd_addr,
    input  logic signed [DATA_W-1:0] Rd_re,
    input  logic signed [DATA_W-1:0] Rd_im,
    output logic                     Busy,
    output logic                     Done,
    output logic [ADDR_W-1:0]        Peak_bin,
    output logic [2*DATA_W:0]        Peak_mag,
    output logic                     Peak_valid
);

    localparam int SQ_W  = 2 * DATA_W;
    localparam int MAG_W = 2 * DATA_W + 1;
    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_BIN);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_BIN);
    localparam logic [MAG_W-1:0]  MIN_M   = MAG_W'(MIN_MAG);

    typedef enum logic [1:0] {
        S_INI   = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                drain_cnt_q, drain_cnt_d;
    logic                v1_q, v1_d;
    logic [ADDR_W-1:0]   bin1_q, bin1_d;
    logic                v2_q, v2_d;
    logic [ADDR_W-1:0]   bin2_q, bin2_d;
    logic [SQ_W-1:0]     sq_re_q, sq_re_d;
    logic [SQ_W-1:0]     sq_im_q, sq_im_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   peak_bin_q, peak_bin_d;
    logic [MAG_W-1:0]    peak_mag_q, peak_mag_d;
    logic                peak_valid_q, peak_valid_d;
    logic signed [SQ_W-1:0] re_ext_s, im_ext_s;
    logic [MAG_W-1:0]    sum_s;

    // Next-state, pipeline and peak-tracking logic.
    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        drain_cnt_d  = drain_cnt_q;
        peak_bin_d   = peak_bin_q;
        peak_mag_d   = peak_mag_q;
        peak_valid_d = peak_valid_q;

        // Squares of signed values are never negative, so the full-width
        // product can be kept as an unsigned value without loss.
        re_ext_s = SQ_W'(Rd_re);
        im_ext_s = SQ_W'(Rd_im);
        sq_re_d  = re_ext_s * re_ext_s;
        sq_im_d  = im_ext_s * im_ext_s;
        sum_s    = {1'b0, sq_re_q} + {1'b0, sq_im_q};

        v1_d   = (state_q == S_READ);
        bin1_d = rd_addr_q;
        v2_d   = v1_q;
        bin2_d = bin1_q;

        // Strict compare keeps the lowest bin on ties.
        if (v2_q && (sum_s > peak_mag_q)) begin
            peak_mag_d   = sum_s;
            peak_bin_d   = bin2_q;
            peak_valid_d = (sum_s > MIN_M);
        end else begin
            peak_mag_d = peak_mag_q;
        end

        case (state_q)
            S_INI: begin
                if (Start) begin
                    state_d      = S_READ;
                    rd_addr_d    = FIRST_A;
                    peak_bin_d   = FIRST_A;
                    peak_mag_d   = {MAG_W{1'b0}};
                    peak_valid_d = 1'b0;
                end else begin
                    state_d = S_INI;
                end
            end
            S_READ: begin
                if (rd_addr_q == LAST_A) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = 1'b0;
                end else begin
                    rd_addr_d = rd_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q) begin
                    state_d = S_DONE;
                end else begin
                    drain_cnt_d = 1'b1;
                end
            end
            S_DONE: begin
                if (Ack) begin
                    state_d = S_INI;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_INI;
            end
        endcase

        busy_d = (state_d == S_READ) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // State, pipeline and output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= S_INI;
            rd_addr_q    <= {ADDR_W{1'b0}};
            drain_cnt_q  <= 1'b0;
            v1_q         <= 1'b0;
            bin1_q       <= {ADDR_W{1'b0}};
            v2_q         <= 1'b0;
            bin2_q       <= {ADDR_W{1'b0}};
            sq_re_q      <= {SQ_W{1'b0}};
            sq_im_q      <= {SQ_W{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            peak_bin_q   <= {ADDR_W{1'b0}};
            peak_mag_q   <= {MAG_W{1'b0}};
            peak_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            drain_cnt_q  <= drain_cnt_d;
            v1_q         <= v1_d;
            bin1_q       <= bin1_d;
            v2_q         <= v2_d;
            bin2_q       <= bin2_d;
            sq_re_q      <= sq_re_d;
            sq_im_q      <= sq_im_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            peak_bin_q   <= peak_bin_d;
            peak_mag_q   <= peak_mag_d;
            peak_valid_q <= peak_valid_d;
        end
    end

    assign Rd_addr    = rd_addr_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Peak_bin   = peak_bin_q;
    assign Peak_mag   = peak_mag_q;
    assign Peak_valid = peak_valid_q;

endmodule

// File: tb/tb_veritune_peak_bin_finder.sv
// Scoreboard bench for veritune_peak_bin_finder: directed buffer contents,
// expected peaks queued at Start, compared by a monitor when Done rises.
module tb_veritune_peak_bin_finder;

    logic               Clk;
    logic               Reset_n;
    logic               Start;
    logic               Ack;
    logic [9:0]         Rd_addr;
    logic signed [31:0] Rd_re;
    logic signed [31:0] Rd_im;
    logic               Busy;
    logic               Done;
    logic [9:0]         Peak_bin;
    logic [64:0]        Peak_mag;
    logic               Peak_valid;

    logic signed [31:0] re_mem [0:1023];
    logic signed [31:0] im_mem [0:1023];

    logic [9:0]  exp_bin_q [$];
    logic [64:0] exp_mag_q [$];
    logic        exp_val_q [$];

    int checks;
    int passes;
    int addr_bad;
    int cyc;

    veritune_peak_bin_finder dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Start      (Start),
        .Ack        (Ack),
        .Rd_addr    (Rd_addr),
        .Rd_re      (Rd_re),
        .Rd_im      (Rd_im),
        .Busy       (Busy),
        .Done       (Done),
        .Peak_bin   (Peak_bin),
        .Peak_mag   (Peak_mag),
        .Peak_valid (Peak_valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Cycle counter and synchronous-read result buffer.
    always @(posedge Clk) begin
        cyc   <= cyc + 1;
        Rd_re <= re_mem[Rd_addr];
        Rd_im <= im_mem[Rd_addr];
    end

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill(input logic signed [31:0] re_v, input logic signed [31:0] im_v);
        for (int i = 0; i < 1024; i++) begin
            re_mem[i] = re_v;
            im_mem[i] = im_v;
        end
    endtask

    task automatic monitor();
        logic prev_busy;
        logic prev_done;
        int   start_cyc;
        prev_busy = 1'b0;
        prev_done = 1'b0;
        start_cyc = 0;
        forever begin
            @(negedge Clk);
            if (Busy && !prev_busy) start_cyc = cyc;
            if (Busy && ((Rd_addr < 10'd1) || (Rd_addr > 10'd511))) addr_bad++;
            if (Done && !prev_done) begin
                if (exp_bin_q.size() == 0) begin
                    chk("unexpected_done", 65'd1, 65'd0);
                end else begin
                    chk("peak_bin", 65'(Peak_bin), 65'(exp_bin_q.pop_front()));
                    chk("peak_mag", Peak_mag, exp_mag_q.pop_front());
                    chk("peak_valid", 65'(Peak_valid), 65'(exp_val_q.pop_front()));
                    chk("done_latency", 65'(cyc - start_cyc), 65'd513);
                end
            end
            prev_busy = Busy;
            prev_done = Done;
        end
    endtask

    task automatic run_scan(input logic [9:0] eb, input logic [64:0] em, input logic ev, input bit poke);
        int n;
        exp_bin_q.push_back(eb);
        exp_mag_q.push_back(em);
        exp_val_q.push_back(ev);
        @(negedge Clk) Start = 1'b1;
        @(negedge Clk) Start = 1'b0;
        if (poke) begin
            repeat (100) @(negedge Clk);
            Start = 1'b1;
            @(negedge Clk) Start = 1'b0;
            repeat (409) @(negedge Clk);
            Start = 1'b1;
            @(negedge Clk) Start = 1'b0;
        end
        n = 0;
        while (!Done && n < 700) begin
            @(negedge Clk);
            n++;
        end
        chk("done_timeout", 65'(Done), 65'd1);
        if (poke) begin
            Start = 1'b1;
            repeat (3) @(negedge Clk);
            Start = 1'b0;
            chk("start_in_done_busy", 65'(Busy), 65'd0);
            chk("start_in_done_done", 65'(Done), 65'd1);
            chk("start_in_done_bin", 65'(Peak_bin), 65'(eb));
        end
        Ack = 1'b1;
        @(negedge Clk) Ack = 1'b0;
        chk("ack_done_drop", 65'(Done), 65'd0);
        chk("ack_busy", 65'(Busy), 65'd0);
        chk("ack_hold_bin", 65'(Peak_bin), 65'(eb));
        @(negedge Clk);
        chk("no_restart", 65'(Busy), 65'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_addr"}, 65'(Rd_addr), 65'd0);
        chk({tag, "_busy"}, 65'(Busy), 65'd0);
        chk({tag, "_done"}, 65'(Done), 65'd0);
        chk({tag, "_peak_bin"}, 65'(Peak_bin), 65'd0);
        chk({tag, "_peak_mag"}, Peak_mag, 65'd0);
        chk({tag, "_peak_valid"}, 65'(Peak_valid), 65'd0);
    endtask

    initial begin
        checks   = 0;
        passes   = 0;
        addr_bad = 0;
        cyc      = 0;
        Reset_n  = 1'b0;
        Start    = 1'b0;
        Ack      = 1'b0;
        fill(32'sd0, 32'sd0);
        fork
            monitor();
        join_none
        repeat (3) @(negedge Clk);
        chk_reset_outputs("por");
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        // Single tone at bin 37
        fill(32'sd0, 32'sd0);
        re_mem[37] = 32'sd1000;
        run_scan(10'd37, 65'd1000000, 1'b1, 1'b0);

        // Tie between bin 10 (3,4) and bin 200 (-5,0): lowest bin wins
        fill(32'sd0, 32'sd0);
        re_mem[10]  = 32'sd3;
        im_mem[10]  = 32'sd4;
        re_mem[200] = -32'sd5;
        run_scan(10'd10, 65'd25, 1'b1, 1'b0);

        // Full-scale corner at the last bin
        fill(32'sd1, 32'sd1);
        re_mem[511] = 32'sh8000_0000;
        im_mem[511] = 32'sh8000_0000;
        run_scan(10'd511, 65'h0_8000_0000_0000_0000, 1'b1, 1'b0);

        // Only unscanned bins carry energy
        fill(32'sd0, 32'sd0);
        re_mem[0]   = 32'sd9999;
        im_mem[0]   = 32'sd9999;
        re_mem[512] = 32'sd5000;
        re_mem[900] = 32'sd7000;
        run_scan(10'd1, 65'd0, 1'b0, 1'b0);

        // Start pokes in READ, DRAIN and DONE must not restart the scan
        fill(32'sd2, -32'sd2);
        re_mem[300] = -32'sd7;
        im_mem[300] = 32'sd1;
        run_scan(10'd300, 65'd50, 1'b1, 1'b1);

        // Reset in the middle of a scan
        fill(32'sd0, 32'sd0);
        re_mem[400] = 32'sd12;
        @(negedge Clk) Start = 1'b1;
        @(negedge Clk) Start = 1'b0;
        repeat (100) @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1 chk_reset_outputs("midscan");
        @(negedge Clk) Reset_n = 1'b1;
        repeat (600) @(negedge Clk);
        chk("abort_no_done", 65'(Done), 65'd0);
        chk("abort_idle", 65'(Busy), 65'd0);

        chk("rd_addr_range", 65'(addr_bad), 65'd0);
        chk("scoreboard_empty", 65'(exp_bin_q.size()), 65'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
